// File: rtl/line_raster_engine_pkg.sv
// Shared types for the Bresenham line rasteriser: default coordinate width,
// packed line descriptor and the raster FSM state encoding.
package line_raster_engine_pkg;

  localparam int unsigned LINE_BITS_DEF = 7;

  // Field order fixes the packing of line_i: x0 occupies the MSBs.
  typedef struct packed {
    logic [LINE_BITS_DEF-1:0] x0;
    logic [LINE_BITS_DEF-1:0] y0;
    logic [LINE_BITS_DEF-1:0] x1;
    logic [LINE_BITS_DEF-1:0] y1;
  } line_t;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_SETUP,
    RS_STEP,
    RS_THICK
  } raster_state_t;

endpackage

// File: rtl/line_raster_engine_setup.sv
// Combinational line setup: per-axis deltas, step directions, major-axis
// selection and the initial Bresenham decision term.
module line_setup_calc
  import line_raster_engine_pkg::*;
#(
  parameter int unsigned LINE_BITS = LINE_BITS_DEF
) (
  input  logic [LINE_BITS-1:0]        x0,
  input  logic [LINE_BITS-1:0]        y0,
  input  logic [LINE_BITS-1:0]        x1,
  input  logic [LINE_BITS-1:0]        y1,
  output logic [LINE_BITS-1:0]        major,
  output logic [LINE_BITS-1:0]        minor,
  output logic                        x_major,
  output logic                        sx_neg,
  output logic                        sy_neg,
  output logic signed [LINE_BITS+1:0] err_init
);

  logic [LINE_BITS-1:0] dx;
  logic [LINE_BITS-1:0] dy;

  always_comb begin
    sx_neg   = (x1 < x0);
    sy_neg   = (y1 < y0);
    dx       = sx_neg ? (x0 - x1) : (x1 - x0);
    dy       = sy_neg ? (y0 - y1) : (y1 - y0);
    x_major  = (dx >= dy);
    major    = x_major ? dx : dy;
    minor    = x_major ? dy : dx;
    // 2*minor - major, both operands zero-extended into the signed width
    err_init = $signed({1'b0, minor, 1'b0}) - $signed({2'b00, major});
  end

endmodule

// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: accepts one line per handshake and streams every
// covered pixel (optionally with a 1-pixel thickening offset) under back-pressure.
module line_raster_engine
  import line_raster_engine_pkg::*;
#(
  parameter int unsigned LINE_BITS = LINE_BITS_DEF,
  parameter bit          THICK_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   line_valid_i,
  output logic                   line_ready_o,
  input  logic [4*LINE_BITS-1:0] line_i,
  input  logic                   thick_i,
  output logic                   pix_valid_o,
  input  logic                   pix_ready_i,
  output logic [LINE_BITS-1:0]   pix_x_o,
  output logic [LINE_BITS-1:0]   pix_y_o,
  output logic                   pix_last_o,
  output logic                   busy_o
);

  localparam logic [LINE_BITS-1:0] COORD_MAX = '1;
  localparam logic [LINE_BITS-1:0] COORD_ONE = LINE_BITS'(1);

  raster_state_t state;

  logic [LINE_BITS-1:0]        x0, y0, x1, y1;
  logic                        thick;
  logic [LINE_BITS-1:0]        x, y, count, major, minor;
  logic                        x_major, sx_neg, sy_neg;
  logic signed [LINE_BITS+1:0] err;

  logic [LINE_BITS-1:0]        s_major, s_minor;
  logic                        s_x_major, s_sx_neg, s_sy_neg;
  logic signed [LINE_BITS+1:0] s_err;

  logic [LINE_BITS-1:0]        nx, ny;
  logic signed [LINE_BITS+1:0] nerr;
  logic                        setup_thick, cur_thick, next_thick;
  logic                        handshake, go_thick, go_done, go_adv;

  line_setup_calc #(
    .LINE_BITS (LINE_BITS)
  ) u_setup (
    .x0       (x0),
    .y0       (y0),
    .x1       (x1),
    .y1       (y1),
    .major    (s_major),
    .minor    (s_minor),
    .x_major  (s_x_major),
    .sx_neg   (s_sx_neg),
    .sy_neg   (s_sy_neg),
    .err_init (s_err)
  );

  // One Bresenham advance from the current point
  always_comb begin
    nx   = x;
    ny   = y;
    nerr = err;
    if (!err[LINE_BITS+1] && (err != '0)) begin
      nerr = err - $signed({1'b0, major, 1'b0});
      if (x_major) ny = sy_neg ? (y - COORD_ONE) : (y + COORD_ONE);
      else         nx = sx_neg ? (x - COORD_ONE) : (x + COORD_ONE);
    end
    nerr = nerr + $signed({1'b0, minor, 1'b0});
    if (x_major) nx = sx_neg ? (x - COORD_ONE) : (x + COORD_ONE);
    else         ny = sy_neg ? (y - COORD_ONE) : (y + COORD_ONE);
  end

  // Thick pixel exists only when its offset coordinate stays in range
  always_comb begin
    setup_thick = thick && (s_x_major ? (y0 != COORD_MAX) : (x0 != COORD_MAX));
    cur_thick   = thick && (x_major ? (y != COORD_MAX) : (x != COORD_MAX));
    next_thick  = thick && (x_major ? (ny != COORD_MAX) : (nx != COORD_MAX));
    handshake   = pix_valid_o && pix_ready_i;
    go_thick    = handshake && (state == RS_STEP) && cur_thick;
    go_done     = handshake && !go_thick && (count == '0);
    go_adv      = handshake && !go_thick && (count != '0);
  end

  always_comb begin
    line_ready_o = (state == RS_IDLE) && !reset;
    busy_o       = (state != RS_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RS_IDLE;
      x0          <= '0;
      y0          <= '0;
      x1          <= '0;
      y1          <= '0;
      thick       <= 1'b0;
      x           <= '0;
      y           <= '0;
      count       <= '0;
      major       <= '0;
      minor       <= '0;
      x_major     <= 1'b0;
      sx_neg      <= 1'b0;
      sy_neg      <= 1'b0;
      err         <= '0;
      pix_valid_o <= 1'b0;
      pix_x_o     <= '0;
      pix_y_o     <= '0;
      pix_last_o  <= 1'b0;
    end else begin
      case (state)
        RS_IDLE: begin
          if (line_valid_i) begin
            {x0, y0, x1, y1} <= line_i;
            thick            <= thick_i & THICK_EN;
            state            <= RS_SETUP;
          end
        end
        RS_SETUP: begin
          x           <= x0;
          y           <= y0;
          err         <= s_err;
          count       <= s_major;
          major       <= s_major;
          minor       <= s_minor;
          x_major     <= s_x_major;
          sx_neg      <= s_sx_neg;
          sy_neg      <= s_sy_neg;
          pix_valid_o <= 1'b1;
          pix_x_o     <= x0;
          pix_y_o     <= y0;
          pix_last_o  <= (s_major == '0) && !setup_thick;
          state       <= RS_STEP;
        end
        default: begin
          // Outputs are registered, so last-ness of the next pixel is decided here
          if (go_thick) begin
            pix_x_o    <= x_major ? x : (x + COORD_ONE);
            pix_y_o    <= x_major ? (y + COORD_ONE) : y;
            pix_last_o <= (count == '0);
            state      <= RS_THICK;
          end else if (go_done) begin
            pix_valid_o <= 1'b0;
            pix_last_o  <= 1'b0;
            state       <= RS_IDLE;
          end else if (go_adv) begin
            x          <= nx;
            y          <= ny;
            err        <= nerr;
            count      <= count - COORD_ONE;
            pix_x_o    <= nx;
            pix_y_o    <= ny;
            pix_last_o <= (count == COORD_ONE) && !next_thick;
            state      <= RS_STEP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_raster_engine.sv
// Directed bench for line_raster_engine: a closed-form rasterisation model
// feeds an expected-pixel queue that a negedge monitor checks every handshake.
module tb_line_raster_engine;
  import line_raster_engine_pkg::*;

  localparam int LB   = LINE_BITS_DEF;
  localparam int MAXC = (1 << LB) - 1;

  typedef struct {
    int x;
    int y;
    bit last;
  } pix_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          line_valid_i = 1'b0;
  logic          line_ready_o;
  logic [4*LB-1:0] line_i = '0;
  logic          thick_i = 1'b0;
  logic          pix_valid_o;
  logic          pix_ready_i = 1'b0;
  logic [LB-1:0] pix_x_o;
  logic [LB-1:0] pix_y_o;
  logic          pix_last_o;
  logic          busy_o;

  int   vectors = 0;
  int   miscompares = 0;
  int   hs_count = 0;
  pix_t exp_q[$];
  pix_t model_q[$];
  pix_t mon_e;
  bit   stalled = 1'b0;
  int   held = 0;
  int   xs[$];
  int   ys[$];

  always #5 clk = ~clk;

  line_raster_engine #(
    .LINE_BITS (LB),
    .THICK_EN  (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .line_valid_i (line_valid_i),
    .line_ready_o (line_ready_o),
    .line_i       (line_i),
    .thick_i      (thick_i),
    .pix_valid_o  (pix_valid_o),
    .pix_ready_i  (pix_ready_i),
    .pix_x_o      (pix_x_o),
    .pix_y_o      (pix_y_o),
    .pix_last_o   (pix_last_o),
    .busy_o       (busy_o)
  );

  function automatic int enc(int x, int y, bit l);
    return (x * 256 + y) * 2 + int'(l);
  endfunction

  task automatic chk(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // Minor offset at major step i is round-half-down of i*minor/major
  function automatic void model_line(int x0, int y0, int x1, int y1, bit thick);
    int dx, dy, sx, sy, maj, mnr, k, px, py;
    bit xm;
    pix_t p;
    dx  = (x1 >= x0) ? x1 - x0 : x0 - x1;
    dy  = (y1 >= y0) ? y1 - y0 : y0 - y1;
    sx  = (x1 >= x0) ? 1 : -1;
    sy  = (y1 >= y0) ? 1 : -1;
    xm  = (dx >= dy);
    maj = xm ? dx : dy;
    mnr = xm ? dy : dx;
    model_q.delete();
    for (int i = 0; i <= maj; i++) begin
      k  = (maj == 0) ? 0 : (2 * i * mnr + maj - 1) / (2 * maj);
      px = xm ? x0 + sx * i : x0 + sx * k;
      py = xm ? y0 + sy * k : y0 + sy * i;
      p  = '{px, py, 1'b0};
      model_q.push_back(p);
      if (thick && (xm ? (py < MAXC) : (px < MAXC))) begin
        p = xm ? '{px, py + 1, 1'b0} : '{px + 1, py, 1'b0};
        model_q.push_back(p);
      end
    end
    model_q[model_q.size() - 1].last = 1'b1;
  endfunction

  task automatic pin_model(string name, input int ex[$], input int ey[$]);
    chk({name, "_len"}, model_q.size(), ex.size());
    for (int i = 0; i < ex.size() && i < model_q.size(); i++)
      chk(name, enc(model_q[i].x, model_q[i].y, model_q[i].last),
          enc(ex[i], ey[i], i == ex.size() - 1));
  endtask

  task automatic run_line(int x0, int y0, int x1, int y1, bit thick, bit check_lat);
    line_t l;
    int t = 0;
    while (!line_ready_o && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_wait", line_ready_o, 1);
    model_line(x0, y0, x1, y1, thick);
    foreach (model_q[i]) exp_q.push_back(model_q[i]);
    l.x0 = LB'(x0);
    l.y0 = LB'(y0);
    l.x1 = LB'(x1);
    l.y1 = LB'(y1);
    line_i       = l;
    thick_i      = thick;
    line_valid_i = 1'b1;
    @(posedge clk); #1;
    line_valid_i = 1'b0;
    chk("ready_low_after_accept", line_ready_o, 0);
    chk("busy_after_accept", busy_o, 1);
    if (check_lat) begin
      chk("lat_setup_no_valid", pix_valid_o, 0);
      @(posedge clk); #1;
      chk("lat_first_valid", pix_valid_o, 1);
    end
  endtask

  task automatic wait_done(string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk({name, "_drain"}, exp_q.size(), 0);
    chk({name, "_idle"}, busy_o, 0);
  endtask

  task automatic wait_last_ready(string name);
    int t = 0;
    do begin
      @(negedge clk); #1;
      t++;
    end while (!(pix_valid_o && pix_last_o) && t < 100);
    chk({name, "_last_seen"}, pix_valid_o && pix_last_o, 1);
    @(posedge clk); #1;
    chk({name, "_ready_next"}, line_ready_o, 1);
    chk({name, "_valid_drop"}, pix_valid_o, 0);
    wait_done(name);
  endtask

  // Scoreboard: every handshake consumes one expected pixel; stalls must hold
  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid_held", pix_valid_o, 1);
        chk("stall_data_held", enc(pix_x_o, pix_y_o, pix_last_o), held);
      end
      if (pix_valid_o && pix_ready_i) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          chk("extra_pixel", enc(pix_x_o, pix_y_o, pix_last_o), -1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pixel", enc(pix_x_o, pix_y_o, pix_last_o), enc(mon_e.x, mon_e.y, mon_e.last));
        end
      end
      stalled = pix_valid_o && !pix_ready_i;
      held    = enc(pix_x_o, pix_y_o, pix_last_o);
    end
  end

  initial begin
    int t;
    int base;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", pix_valid_o, 0);
    chk("rst_xy", enc(pix_x_o, pix_y_o, pix_last_o), 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", line_ready_o, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", line_ready_o, 1);

    model_line(0, 0, 5, 2, 1'b0);
    xs = '{0, 1, 2, 3, 4, 5};
    ys = '{0, 0, 1, 1, 2, 2};
    pin_model("model_shallow", xs, ys);
    model_line(0, 0, 3, 0, 1'b1);
    xs = '{0, 0, 1, 1, 2, 2, 3, 3};
    ys = '{0, 1, 0, 1, 0, 1, 0, 1};
    pin_model("model_thick", xs, ys);
    model_line(0, 127, 3, 127, 1'b1);
    xs = '{0, 1, 2, 3};
    ys = '{127, 127, 127, 127};
    pin_model("model_thick_edge", xs, ys);
    model_line(5, 5, 5, 5, 1'b0);
    xs = '{5};
    ys = '{5};
    pin_model("model_point", xs, ys);
    model_line(3, 10, 0, 0, 1'b0);
    chk("model_steep_len", model_q.size(), 11);
    chk("model_steep_first", enc(model_q[0].x, model_q[0].y, model_q[0].last), enc(3, 10, 0));
    chk("model_steep_end", enc(model_q[10].x, model_q[10].y, model_q[10].last), enc(0, 0, 1));

    pix_ready_i = 1'b1;
    run_line(0, 0, 5, 2, 1'b0, 1'b1);
    wait_last_ready("shallow");
    run_line(5, 5, 5, 5, 1'b0, 1'b1);
    wait_last_ready("point");
    run_line(3, 10, 0, 0, 1'b0, 1'b0);
    wait_done("steep_neg");
    run_line(0, 0, 3, 0, 1'b1, 1'b0);
    wait_done("thick_x");
    run_line(0, 127, 3, 127, 1'b1, 1'b0);
    wait_done("thick_y_edge");
    run_line(0, 0, 1, 3, 1'b1, 1'b0);
    wait_done("thick_ymajor");
    run_line(127, 0, 127, 2, 1'b1, 1'b0);
    wait_done("thick_x_edge");
    run_line(5, 5, 5, 5, 1'b1, 1'b0);
    wait_done("point_thick");

    pix_ready_i = 1'b0;
    run_line(0, 0, 7, 3, 1'b0, 1'b0);
    t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 400) begin
      pix_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      t++;
    end
    chk("stall_drain", exp_q.size(), 0);
    pix_ready_i = 1'b1;

    base = hs_count;
    run_line(0, 0, 9, 9, 1'b0, 1'b0);
    t = 0;
    while (hs_count < base + 3 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    chk("mid_line_handshakes", hs_count - base, 3);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid", pix_valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", line_ready_o, 0);
    chk("midrst_xy", enc(pix_x_o, pix_y_o, pix_last_o), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_ready_after", line_ready_o, 1);
    run_line(1, 1, 2, 2, 1'b0, 1'b1);
    wait_last_ready("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
